logic_pipe: RTL
===============

LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits (1..64).
REQ-002 Parameter CNT_W, default 16: width of the delivered-result counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select, sampled with the beat.
REQ-010 out_valid  output  1  result beat offered.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 y  output  WIDTH  result.
REQ-013 out_zero  output  1  result is all zeros (flag feature).
REQ-014 out_par  output  1  XOR-reduction of result (flag feature).
REQ-015 res_cnt  output  CNT_W  count of delivered results.

Function
REQ-016 op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 pass a; all bitwise over WIDTH.
REQ-017 Beat accepted when in_valid && in_ready; delivered when out_valid && out_ready.
REQ-018 Two register stages: S1 captures a, b, op; S2 captures computed y (and flags).
REQ-019 Latency exactly 2 cycles from accept edge to out_valid high, with no backpressure.
REQ-020 Throughput 1 beat/cycle while out_ready stays high.
REQ-021 S2 loads when empty or delivering; S1 loads when empty or S2 loads from it.
REQ-022 in_ready = !S1_valid || S2_load; combinational from out_ready, no other input paths.
REQ-023 With out_ready low, at most 2 beats held; in_ready falls once both stages full.
REQ-024 y, flags, out_valid stable while out_valid && !out_ready; no beat dropped or duplicated.
REQ-025 res_cnt increments by 1 per delivery, wraps from 2^CNT_W-1 to 0.
REQ-026 Simultaneous accept and deliver in one cycle: both occur, occupancy unchanged.
REQ-027 Inputs a, b, op ignored when not accepted.

Reset
REQ-028 rst_n low clears S1/S2 valid, y, out_zero, out_par, res_cnt to 0 immediately, clock-independent.
REQ-029 in_ready is 1 and out_valid is 0 while rst_n low and on the first cycle after release.
REQ-030 Reset mid-operation discards all in-flight beats; no partial result delivered after release.

Configuration
REQ-031 Macro LOGIC_PIPE_FLAGS_EN defined: out_zero and out_par computed from S1 result, registered in S2 alongside y.
REQ-032 Macro undefined: no flag registers; out_zero and out_par tied to 0; all other behaviour identical.

Structure
REQ-033 Shared package logic_pipe_pkg holds the 3-bit op typedef and the eight op constants.
REQ-034 Combinational op decode in one sub-module logic_op_unit (a, b, op -> y), instantiated between S1 and S2.

Verification (WIDTH=8)
REQ-035 Each op with a=8'hC3, b=8'h5A, out_ready=1 -> y = 42,DB,99,BD,24,66,3C,C3 two cycles after accept.
REQ-036 Burst of 10 beats, out_ready=1 -> 10 results in order, one per cycle, res_cnt=10.
REQ-037 out_ready=0, 3 beats offered -> 2 accepted, in_ready=0, y held; out_ready=1 -> all 3 delivered in order.
REQ-038 Flags on, op=XOR, a=b=8'h7E -> y=8'h00, out_zero=1, out_par=0; a=8'h01, b=0 -> out_zero=0, out_par=1.
REQ-039 rst_n pulsed low with 2 beats in flight -> out_valid=0, res_cnt=0 at once, no stale result after release.
REQ-040 CNT_W=4, 17 deliveries -> res_cnt wraps to 1.

Source files
------------

// File: rtl/logic_pipe_pkg.sv
// Shared types for the logic_pipe block: 3-bit bitwise op select and pipeline depth.
package logic_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASA = 3'd7
  } op_e;

  localparam int STAGES = 2;

endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: combinational bitwise op decode, a/b/op -> y over WIDTH bits.
module logic_op_unit
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASA: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage valid/ready bitwise pipeline with a delivered-result counter.
// Define LOGIC_PIPE_FLAGS_EN to register out_zero/out_par alongside y; otherwise both tie to 0.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_zero,
  output logic             out_par,
  output logic [CNT_W-1:0] res_cnt
);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_req_t;

  logic [STAGES:1] vld_pipe;
  s1_req_t         s1_q;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] cnt_q;
  logic            s2_free, s2_load, s1_load, deliver;

  // S2 frees up when empty or its result leaves this cycle; S1 then drains into it.
  assign s2_free  = !vld_pipe[2] || out_ready;
  assign s2_load  = vld_pipe[1] && s2_free;
  assign in_ready = !vld_pipe[1] || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign deliver  = vld_pipe[2] && out_ready;

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .a  (s1_q.a),
    .b  (s1_q.b),
    .op (s1_q.op),
    .y  (s1_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s1_load)  s1_q <= '{op: op, a: a, b: b};
      if (s2_free)  vld_pipe[2] <= vld_pipe[1];
      if (s2_load)  y_q <= s1_y;
      if (deliver)  cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef LOGIC_PIPE_FLAGS_EN
  logic zero_q, par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (s2_load) begin
      zero_q <= (s1_y == '0);
      par_q  <= ^s1_y;
    end
  end

  assign out_zero = zero_q;
  assign out_par  = par_q;
`else
  assign out_zero = 1'b0;
  assign out_par  = 1'b0;
`endif

  assign out_valid = vld_pipe[2];
  assign y         = y_q;
  assign res_cnt   = cnt_q;

endmodule
